op_display_ctrl: RTL and testbench

OP_DISPLAY_CTRL -- requirements
Module: op_display_ctrl

---
 rtl/op_display_pkg.sv | 32 +++
 rtl/key_debounce.sv | 44 ++++
 rtl/op_display_ctrl.sv | 115 +++++++++++
 tb/tb_op_display_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_display_pkg.sv
// Shared types and 7-segment glyphs for the operation selector display.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package op_display_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EDIT = 1'b1
   } op_state_e;

   // ALU glyphs: A(add) S(sub) n(and) o(or) H(xor) L(shl) r(shr) C(cmp)
   localparam logic [7:0][6:0] SYM_TABLE = {
      7'b0111001,
      7'b1010000,
      7'b0111000,
      7'b1110110,
      7'b1011100,
      7'b1010100,
      7'b1101101,
      7'b1110111
   };

   localparam logic [6:0] BLANK_PAT = 7'b0000000;
   localparam logic [6:0] ERR_PAT   = 7'b1111001;

   function automatic logic [6:0] op_symbol(input logic [3:0] idx);
      logic [6:0] pat;
      pat = BLANK_PAT;
      if (idx < 4'd8) pat = SYM_TABLE[idx[2:0]];
      return pat;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer, consecutive-sample debouncer,
// and a one-cycle press pulse on a debounced 1->0 transition.
module key_debounce #(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

   logic sync_1;
   logic sync_2;
   logic stable;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_1 <= key_raw;
         sync_2 <= sync_1;
         press  <= 1'b0;
         // cnt tracks how many samples in a row have disagreed with stable
         if (sync_2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= sync_2;
            cnt    <= '0;
            press  <= ~sync_2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/op_display_ctrl.sv
// Operation selector: KEY0 steps a pending index, KEY1 commits it to OP_CODE,
// and a 7-segment digit shows the committed op or blinks the pending one.
module op_display_ctrl
   import op_display_pkg::*;
#(
   parameter int N_OPS        = 8,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int BLINK_CYC    = 12500000,
   parameter bit ACTIVE_LOW   = 1'b1,
   localparam int OP_W        = $clog2(N_OPS)
) (
   input  logic            MAX10_CLK1_50,
   input  logic            RST,
   input  logic            KEY0,
   input  logic            KEY1,
   input  logic            SW9,
   input  logic            ERR,
   output logic [OP_W-1:0] OP_CODE,
   output logic            OP_VALID,
   output logic [6:0]      HEX,
   output op_state_e       dbg_state,
   output logic [OP_W-1:0] dbg_pending
);

   localparam int BLK_W = $clog2(BLINK_CYC + 1);
   localparam logic [BLK_W-1:0] BLINK_MAX = BLK_W'(BLINK_CYC - 1);
   localparam logic [OP_W-1:0]  LAST_OP   = OP_W'(N_OPS - 1);
   localparam logic [6:0]       POL_MASK  = ACTIVE_LOW ? 7'h7F : 7'h00;

   op_state_e        state;
   logic [OP_W-1:0]  pending;
   logic [OP_W-1:0]  next_idx;
   logic [BLK_W-1:0] blink_cnt;
   logic             phase_on;
   logic             next_press;
   logic             commit_press;
   logic             next_ev;
   logic             commit_ev;
   logic [6:0]       hex_next;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_next (
      .clk     (MAX10_CLK1_50),
      .rst     (RST),
      .key_raw (KEY0),
      .press   (next_press)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_commit (
      .clk     (MAX10_CLK1_50),
      .rst     (RST),
      .key_raw (KEY1),
      .press   (commit_press)
   );

   assign next_ev     = next_press & ~SW9 & ~ERR;
   assign commit_ev   = commit_press & ~SW9 & ~ERR;
   assign next_idx    = (pending == LAST_OP) ? '0 : pending + OP_W'(1);
   assign dbg_state   = state;
   assign dbg_pending = pending;

   always_ff @(posedge MAX10_CLK1_50) begin
      if (RST) begin
         state     <= ST_IDLE;
         pending   <= '0;
         OP_CODE   <= '0;
         OP_VALID  <= 1'b0;
         blink_cnt <= '0;
         phase_on  <= 1'b1;
      end else begin
         OP_VALID <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Holding the blink timer at its start makes every EDIT entry begin lit
               blink_cnt <= '0;
               phase_on  <= 1'b1;
               if (next_ev && !commit_ev) begin
                  pending <= next_idx;
                  state   <= ST_EDIT;
               end
            end
            ST_EDIT: begin
               if (blink_cnt == BLINK_MAX) begin
                  blink_cnt <= '0;
                  phase_on  <= ~phase_on;
               end else begin
                  blink_cnt <= blink_cnt + BLK_W'(1);
               end
               if (commit_ev) begin
                  OP_CODE  <= pending;
                  OP_VALID <= 1'b1;
                  state    <= ST_IDLE;
               end else if (next_ev) begin
                  pending <= next_idx;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      hex_next = op_symbol(4'(OP_CODE));
      if (ERR) begin
         hex_next = ERR_PAT;
      end else if (state == ST_EDIT) begin
         hex_next = phase_on ? op_symbol(4'(pending)) : BLANK_PAT;
      end
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (RST) HEX <= op_symbol(4'd0) ^ POL_MASK;
      else     HEX <= hex_next ^ POL_MASK;
   end

endmodule

// File: tb/tb_op_display_ctrl.sv
// Bench for op_display_ctrl: per-cycle comparison against a behavioural model
// of the selector plus literal checkpoints after each directed scenario.
module tb_op_display_ctrl;

   localparam int DB   = 4;
   localparam int BL   = 8;
   localparam int NOPS = 8;

   localparam logic [6:0] SYM [8] = '{
      7'b1110111, 7'b1101101, 7'b1010100, 7'b1011100,
      7'b1110110, 7'b0111000, 7'b1010000, 7'b0111001
   };
   localparam logic [6:0] ERR_GLYPH = 7'b1111001;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst, key0, key1, sw9, err;
   logic [2:0] op_code;
   logic       op_valid;
   logic [6:0] hex;
   logic [0:0] dbg_state;
   logic [2:0] dbg_pending;

   always #5 clk = ~clk;

   op_display_ctrl #(
      .N_OPS(NOPS), .DEBOUNCE_CYC(DB), .BLINK_CYC(BL), .ACTIVE_LOW(1'b0)
   ) dut (
      .MAX10_CLK1_50 (clk),
      .RST           (rst),
      .KEY0          (key0),
      .KEY1          (key1),
      .SW9           (sw9),
      .ERR           (err),
      .OP_CODE       (op_code),
      .OP_VALID      (op_valid),
      .HEX           (hex),
      .dbg_state     (dbg_state),
      .dbg_pending   (dbg_pending)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;
   int valid_cnt = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit   hist [2][$];
   bit   samp [2][$];
   bit   m_stable [2];
   bit   m_press [2];
   bit   m_edit;
   int   m_pend, m_code, m_k;
   logic [6:0] exp_hex;
   bit   exp_valid;

   function automatic logic [6:0] sym(input int i);
      return (i < 8) ? SYM[i] : 7'b0000000;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            hist[k].delete();
            hist[k].push_back(1'b1);
            hist[k].push_back(1'b1);
            samp[k].delete();
            m_stable[k] = 1'b1;
            m_press[k]  = 1'b0;
         end
         m_edit = 0; m_pend = 0; m_code = 0; m_k = 0;
         exp_valid = 0;
         exp_hex   = sym(0);
      end else begin
         bit nx, cm;
         // display reflects the state held before this edge
         if (err)          exp_hex = ERR_GLYPH;
         else if (!m_edit) exp_hex = sym(m_code);
         else              exp_hex = (((m_k / BL) % 2) == 0) ? sym(m_pend) : 7'b0000000;
         exp_valid = 0;
         nx = m_press[0] && !sw9 && !err;
         cm = m_press[1] && !sw9 && !err;
         if (m_edit) begin
            m_k++;
            if (cm) begin
               m_code = m_pend; exp_valid = 1; m_edit = 0;
            end else if (nx) begin
               m_pend = (m_pend + 1) % NOPS;
            end
         end else if (nx && !cm) begin
            m_pend = (m_pend + 1) % NOPS; m_edit = 1; m_k = 0;
         end
         // key level accepted once the last DB synchronized samples all disagree
         for (int k = 0; k < 2; k++) begin
            bit s, all_diff;
            hist[k].push_back(k == 0 ? key0 : key1);
            s = hist[k][hist[k].size() - 3];
            if (hist[k].size() > 4) void'(hist[k].pop_front());
            samp[k].push_back(s);
            if (samp[k].size() > DB) void'(samp[k].pop_front());
            all_diff = (samp[k].size() == DB);
            for (int i = 0; i < samp[k].size(); i++)
               if (samp[k][i] == m_stable[k]) all_diff = 0;
            m_press[k] = 1'b0;
            if (all_diff) begin
               m_press[k]  = (s == 1'b0);
               m_stable[k] = s;
               samp[k].delete();
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("op_code",  int'(op_code),     m_code);
         check("op_valid", int'(op_valid),    int'(exp_valid));
         check("hex",      int'(hex),         int'(exp_hex));
         check("state",    int'(dbg_state),   int'(m_edit));
         check("pending",  int'(dbg_pending), m_pend);
         if (op_valid) valid_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit k0, input bit k1);
      key0 = ~k0;
      key1 = ~k1;
      cycles(12);
      key0 = 1'b1;
      key1 = 1'b1;
      cycles(12);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(2);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int v0, blanks, lit;
      key0 = 1'b1; key1 = 1'b1; sw9 = 1'b0; err = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      cycles(2);
      rst = 1'b0;

      // idle after reset
      cycles(10);
      check("rst_op_code", int'(op_code), 0);
      check("rst_hex", int'(hex), int'(7'b1110111));
      check("rst_state", int'(dbg_state), 0);

      // two nexts, blink, commit
      v0 = valid_cnt;
      press(1, 0);
      press(1, 0);
      check("edit_pending", int'(dbg_pending), 2);
      check("edit_state", int'(dbg_state), 1);
      blanks = 0; lit = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (hex == 7'b0000000) blanks++;
         if (hex == 7'b1010100) lit++;
      end
      check("blink_dark_seen", int'(blanks > 0), 1);
      check("blink_lit_seen", int'(lit > 0), 1);
      check("no_valid_before_commit", valid_cnt - v0, 0);
      press(0, 1);
      check("commit_op_code", int'(op_code), 2);
      check("commit_hex", int'(hex), int'(7'b1010100));
      check("commit_pulses", valid_cnt - v0, 1);

      // bouncing KEY0 then held low: single advance
      key0 = 1'b0; cycles(2); key0 = 1'b1; cycles(2);
      key0 = 1'b0; cycles(2); key0 = 1'b1; cycles(2);
      key0 = 1'b0; cycles(14); key0 = 1'b1; cycles(14);
      check("bounce_pending", int'(dbg_pending), 3);
      check("bounce_state", int'(dbg_state), 1);

      // simultaneous next+commit in EDIT: commit wins
      v0 = valid_cnt;
      press(1, 1);
      check("both_op_code", int'(op_code), 3);
      check("both_pending", int'(dbg_pending), 3);
      check("both_pulses", valid_cnt - v0, 1);

      // commit in IDLE is ignored
      v0 = valid_cnt;
      press(0, 1);
      check("idle_commit_pulses", valid_cnt - v0, 0);
      check("idle_commit_state", int'(dbg_state), 0);

      // eight nexts wrap to 0
      do_reset();
      v0 = valid_cnt;
      for (int i = 0; i < 8; i++) press(1, 0);
      check("wrap_pending", int'(dbg_pending), 0);
      check("wrap_state", int'(dbg_state), 1);
      press(0, 1);
      check("wrap_op_code", int'(op_code), 0);
      check("wrap_pulses", valid_cnt - v0, 1);

      // lock switch, then error flag
      press(1, 0);
      v0 = valid_cnt;
      sw9 = 1'b1;
      press(1, 1);
      check("lock_pending", int'(dbg_pending), 1);
      check("lock_state", int'(dbg_state), 1);
      sw9 = 1'b0;
      err = 1'b1;
      cycles(2);
      check("err_hex", int'(hex), int'(7'b1111001));
      press(1, 1);
      check("err_hex_hold", int'(hex), int'(7'b1111001));
      check("err_pending", int'(dbg_pending), 1);
      check("lock_err_pulses", valid_cnt - v0, 0);
      err = 1'b0;
      cycles(3);
      press(0, 1);
      check("after_err_op_code", int'(op_code), 1);
      check("after_err_hex", int'(hex), int'(7'b1101101));

      // reset mid-EDIT abandons the edit
      press(1, 0);
      v0 = valid_cnt;
      do_reset();
      check("rst_edit_op_code", int'(op_code), 0);
      check("rst_edit_state", int'(dbg_state), 0);
      check("rst_edit_pulses", valid_cnt - v0, 0);

      // key held low through reset release
      key0 = 1'b0;
      cycles(3);
      rst = 1'b1; cycles(2); rst = 1'b0;
      cycles(14);
      key0 = 1'b1;
      cycles(14);
      check("held_key_pending", int'(dbg_pending), 1);
      check("held_key_state", int'(dbg_state), 1);

      cycles(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
